// File: rtl/cpu_control_unit_if.sv
// Control bus between the CPU control FSM and the datapath.
// The control unit takes the master view: it reads status and opcode and drives every datapath strobe.
interface cpu_control_unit_if;
    logic       run;
    logic [3:0] opcode;
    logic       zero;
    logic       loadIR;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic       inc_pc;
    logic       load_pc;
    logic       load_acc;
    logic [1:0] acc_src;
    logic       load_reg;
    logic [2:0] alu_op;
    logic       halted;
    logic [7:0] instr_count;

    modport master (
        input  run, opcode, zero,
        output loadIR, mem_rd, mem_wr, addr_sel, inc_pc, load_pc,
               load_acc, acc_src, load_reg, alu_op, halted, instr_count
    );

    modport slave (
        output run, opcode, zero,
        input  loadIR, mem_rd, mem_wr, addr_sel, inc_pc, load_pc,
               load_acc, acc_src, load_reg, alu_op, halted, instr_count
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM for the 8-bit accumulator CPU: fetch, IR load, decode, execute.
// Strobes are a pure decode of the current state and opcode; only state and instr_count are stored.
module cpu_control_unit (
    input  logic                   clk,
    input  logic                   rst_n,
    cpu_control_unit_if.master     bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOADIR = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_MEMRD  = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] instr_count_r;
    logic       boundary_s;
    logic       load_ir_s;
    logic       mem_rd_s;
    logic       mem_wr_s;
    logic       addr_sel_s;
    logic       inc_pc_s;
    logic       load_pc_s;
    logic       load_acc_s;
    logic [1:0] acc_src_s;
    logic       load_reg_s;
    logic [2:0] alu_op_s;
    logic       halted_s;

    // An instruction retires on the last cycle of EXEC or WB.
    assign boundary_s = (state_r == ST_EXEC) || (state_r == ST_WB);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count_r <= 8'd0;
        end else if (boundary_s) begin
            instr_count_r <= instr_count_r + 8'd1;
        end else begin
            instr_count_r <= instr_count_r;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        next_state_s = state_r;
        load_ir_s    = 1'b0;
        mem_rd_s     = 1'b0;
        mem_wr_s     = 1'b0;
        addr_sel_s   = 1'b0;
        inc_pc_s     = 1'b0;
        load_pc_s    = 1'b0;
        load_acc_s   = 1'b0;
        acc_src_s    = 2'd0;
        load_reg_s   = 1'b0;
        alu_op_s     = 3'd0;
        halted_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.run) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                mem_rd_s     = 1'b1;
                next_state_s = ST_LOADIR;
            end
            ST_LOADIR: begin
                mem_rd_s     = 1'b1;
                load_ir_s    = 1'b1;
                inc_pc_s     = 1'b1;
                next_state_s = ST_DECODE;
            end
            ST_DECODE: begin
                case (bus.opcode)
                    4'h8:    next_state_s = ST_MEMRD;
                    4'hF:    next_state_s = ST_HALT;
                    default: next_state_s = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (bus.opcode)
                    4'h1: begin
                        load_acc_s = 1'b1;
                        acc_src_s  = 2'd1;
                    end
                    4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        load_acc_s = 1'b1;
                        alu_op_s   = bus.opcode[2:0] - 3'd2;
                    end
                    4'h9: begin
                        mem_wr_s   = 1'b1;
                        addr_sel_s = 1'b1;
                    end
                    4'hA:    load_reg_s = 1'b1;
                    4'hB:    load_pc_s  = 1'b1;
                    4'hC:    load_pc_s  = bus.zero;
                    4'hD:    load_pc_s  = ~bus.zero;
                    default: load_pc_s  = 1'b0;
                endcase
                if (bus.run) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MEMRD: begin
                mem_rd_s     = 1'b1;
                addr_sel_s   = 1'b1;
                next_state_s = ST_WB;
            end
            ST_WB: begin
                load_acc_s = 1'b1;
                acc_src_s  = 2'd2;
                if (bus.run) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                halted_s     = 1'b1;
                next_state_s = ST_HALT;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.loadIR      = load_ir_s;
    assign bus.mem_rd      = mem_rd_s;
    assign bus.mem_wr      = mem_wr_s;
    assign bus.addr_sel    = addr_sel_s;
    assign bus.inc_pc      = inc_pc_s;
    assign bus.load_pc     = load_pc_s;
    assign bus.load_acc    = load_acc_s;
    assign bus.acc_src     = acc_src_s;
    assign bus.load_reg    = load_reg_s;
    assign bus.alu_op      = alu_op_s;
    assign bus.halted      = halted_s;
    assign bus.instr_count = instr_count_r;
endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized scoreboard bench for cpu_control_unit: the driver pushes the expected
// per-cycle strobe picture of each instruction, a negedge monitor pops and compares.
module tb_cpu_control_unit;
    logic clk;
    logic rst_n;

    cpu_control_unit_if bus ();

    cpu_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector layout: loadIR mem_rd mem_wr addr_sel inc_pc load_pc load_acc acc_src[2] load_reg alu_op[3] halted
    localparam logic [13:0] S_LIR  = 14'h2000;
    localparam logic [13:0] S_RD   = 14'h1000;
    localparam logic [13:0] S_WR   = 14'h0800;
    localparam logic [13:0] S_AS   = 14'h0400;
    localparam logic [13:0] S_INC  = 14'h0200;
    localparam logic [13:0] S_LPC  = 14'h0100;
    localparam logic [13:0] S_LACC = 14'h0080;
    localparam logic [13:0] S_REG  = 14'h0010;
    localparam logic [13:0] S_HALT = 14'h0001;

    typedef struct {
        logic [21:0] v;
        string       name;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] cnt   = 8'd0;

    function automatic logic [13:0] acc_src_f(input int src);
        return 14'(src) << 5;
    endfunction

    function automatic logic [13:0] alu_f(input int op);
        return 14'(op) << 1;
    endfunction

    // What the EXEC cycle of each opcode must do.
    function automatic logic [13:0] exec_vec(input logic [3:0] op, input logic z);
        int o;
        o = int'(op);
        if (o == 1)                return S_LACC | acc_src_f(1);
        if (o >= 2 && o <= 7)      return S_LACC | alu_f(o - 2);
        if (o == 9)                return S_WR | S_AS;
        if (o == 10)               return S_REG;
        if (o == 11)               return S_LPC;
        if (o == 12)               return z ? S_LPC : 14'd0;
        if (o == 13)               return z ? 14'd0 : S_LPC;
        return 14'd0;
    endfunction

    // Monitor: compares the DUT picture against the oldest expectation each cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [21:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {bus.loadIR, bus.mem_rd, bus.mem_wr, bus.addr_sel, bus.inc_pc,
                   bus.load_pc, bus.load_acc, bus.acc_src, bus.load_reg,
                   bus.alu_op, bus.halted, bus.instr_count};
            tests = tests + 1;
            if (act !== e.v) begin
                fails = fails + 1;
                $display("FAIL %s @%0t: got strobes=%b count=%0d, expected strobes=%b count=%0d",
                         e.name, $time, act[21:8], act[7:0], e.v[21:8], e.v[7:0]);
            end
        end
    end

    // Record the expectation for the current cycle, then advance one clock.
    task automatic cyc(input string nm, input logic [13:0] v);
        exp_t e;
        e.v    = {v, cnt};
        e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Called in the FETCH cycle; run_next is what run holds at the instruction boundary.
    task automatic do_instr(input logic [3:0] op, input logic z, input logic run_next);
        bus.opcode = 4'($urandom_range(0, 15));
        bus.zero   = 1'($urandom_range(0, 1));
        cyc("fetch", S_RD);
        bus.opcode = 4'($urandom_range(0, 15));
        cyc("loadir", S_RD | S_LIR | S_INC);
        bus.opcode = op;
        bus.zero   = z;
        bus.run    = run_next;
        cyc("decode", 14'd0);
        if (op == 4'h8) begin
            cyc("memrd", S_RD | S_AS);
            cyc("wb", S_LACC | acc_src_f(2));
            cnt = cnt + 8'd1;
        end else if (op != 4'hF) begin
            cyc("exec", exec_vec(op, z));
            cnt = cnt + 8'd1;
        end
    endtask

    // Sit in IDLE for n cycles, raising run in the last so FETCH follows.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.run = (i == n - 1);
            cyc("idle", 14'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        logic       rn;
        rst_n      = 1'b0;
        bus.run    = 1'b1;
        bus.opcode = 4'h0;
        bus.zero   = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cyc("reset", 14'd0);
        rst_n = 1'b1;
        cyc("idle_release", 14'd0);

        // Directed: LDI, ADD, LD, ST, branch cases.
        do_instr(4'h1, 1'b0, 1'b1);
        do_instr(4'h2, 1'b1, 1'b1);
        do_instr(4'h8, 1'b0, 1'b1);
        do_instr(4'h9, 1'b0, 1'b1);
        do_instr(4'hC, 1'b1, 1'b1);
        do_instr(4'hC, 1'b0, 1'b1);
        do_instr(4'hD, 1'b0, 1'b1);
        do_instr(4'hD, 1'b1, 1'b1);
        do_instr(4'h7, 1'b0, 1'b1);
        do_instr(4'hE, 1'b1, 1'b1);
        // run dropped in DECODE of ADD, then restarted.
        do_instr(4'h2, 1'b0, 1'b0);
        idle_cycles(3);

        // Random instruction mix with occasional run drops.
        repeat (150) begin
            op = 4'($urandom_range(0, 14));
            rn = ($urandom_range(0, 7) != 0);
            do_instr(op, 1'($urandom_range(0, 1)), rn);
            if (!rn) idle_cycles($urandom_range(1, 3));
        end

        // Reset during LOADIR aborts the instruction.
        bus.opcode = 4'h1;
        cyc("fetch_pre_abort", S_RD);
        rst_n = 1'b0;
        cnt   = 8'd0;
        cyc("reset_in_loadir", 14'd0);
        rst_n   = 1'b1;
        bus.run = 1'b1;
        cyc("idle_after_abort", 14'd0);

        // 256 NOPs: the counter wraps back to zero.
        repeat (256) do_instr(4'h0, 1'($urandom_range(0, 1)), 1'b1);
        do_instr(4'h1, 1'b0, 1'b1);

        // HLT, then reset while halted.
        do_instr(4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            bus.run    = 1'($urandom_range(0, 1));
            bus.opcode = 4'($urandom_range(0, 15));
            cyc("halt", S_HALT);
        end
        bus.run = 1'b0;
        rst_n   = 1'b0;
        cnt     = 8'd0;
        cyc("reset_in_halt", 14'd0);
        rst_n = 1'b1;
        cyc("idle_after_halt", 14'd0);
        idle_cycles(2);
        do_instr(4'h3, 1'b0, 1'b0);
        cyc("idle_end", 14'd0);

        @(posedge clk);
        #1;
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle control FSM for the 8-bit accumulator CPU. It sequences each instruction through fetch, IR load, decode and execute, driving the instruction register load strobe, PC, accumulator, register-file, ALU and memory controls. It consumes the 4-bit opcode held in the instruction register and the ALU zero flag. It sits between the instruction register and the rest of the datapath as the sole source of datapath strobes.

## Interface
- No parameters. Opcode width is fixed at 4 bits and alu_op width at 3 bits.
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- run  input  1  level; 1 allows new instructions to start
- opcode  input  4  opcode from the instruction register; sampled only in DECODE and later states
- zero  input  1  ALU/accumulator zero flag, sampled in EXEC
- loadIR  output  1  instruction register load strobe
- mem_rd  output  1  memory read enable
- mem_wr  output  1  memory write enable
- addr_sel  output  1  memory address source: 0 = PC, 1 = immediate
- inc_pc  output  1  PC <= PC+1
- load_pc  output  1  PC <= immediate
- load_acc  output  1  accumulator load
- acc_src  output  2  accumulator source: 0 = ALU, 1 = immediate, 2 = memory
- load_reg  output  1  register file write (reg[imm] <= acc)
- alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT
- halted  output  1  1 while in HALT
- instr_count  output  8  retired-instruction counter

## Operation
- States: IDLE, FETCH, LOADIR, DECODE, EXEC, MEMRD, WB, HALT.
- IDLE:
  - run=1 -> FETCH; otherwise stay.
- FETCH:
  - mem_rd=1, addr_sel=0.
  - -> LOADIR.
- LOADIR:
  - mem_rd=1, addr_sel=0, loadIR=1, inc_pc=1.
  - -> DECODE.
- DECODE: no strobes; branch on opcode.
  - 8 (LD) -> MEMRD.
  - F (HLT) -> HALT.
  - all others -> EXEC.
- EXEC: strobes depend on opcode.
  - 0 NOP: none.
  - 1 LDI: load_acc, acc_src=1.
  - 2-7 ADD/SUB/AND/OR/XOR/NOT: load_acc, acc_src=0, alu_op = opcode-2.
  - 9 ST: mem_wr, addr_sel=1.
  - A MOV: load_reg.
  - B JMP: load_pc.
  - C JZ: load_pc only if zero=1.
  - D JNZ: load_pc only if zero=0.
  - E (reserved): treated as NOP.
- MEMRD:
  - mem_rd=1, addr_sel=1.
  - -> WB.
- WB:
  - load_acc=1, acc_src=2.
- Instruction boundary (end of EXEC or WB):
  - instr_count increments by 1, wrapping 255 -> 0.
  - -> FETCH if run=1, else IDLE.
- HALT:
  - halted=1, all strobes 0; stays in HALT until reset.
  - HLT does not increment instr_count.
- Output decode:
  - All strobes decode combinationally from the current state and opcode.
  - Any strobe not listed for a state is 0.
  - alu_op defaults to 0 and acc_src defaults to 0.

## Timing
- Reset: state=IDLE and instr_count=0 immediately on rst_n low. All strobes, alu_op, acc_src, addr_sel and halted are 0.
- Reset mid-instruction aborts the instruction; no partial strobes follow release.
- The instruction register captures on the clk edge that ends LOADIR, so opcode is valid from DECODE onward.
- Latency from leaving IDLE or a prior boundary:
  - ALU, LDI, ST, MOV, jump and NOP instructions take 4 cycles (FETCH, LOADIR, DECODE, EXEC).
  - LD takes 5 cycles.
  - HLT reaches HALT after 3 cycles.
- run is sampled only in IDLE and at instruction boundaries. Dropping run mid-instruction completes the current instruction, then enters IDLE.
- Simultaneous load_pc and inc_pc never occur: inc_pc is asserted only in LOADIR.
- mem_rd and mem_wr are never both 1.

## Test plan
- Reset and run: hold rst_n=0, then release with run=1 -> FETCH on the first edge, loadIR=1 in cycle 2, instr_count=0 until the first boundary.
- LDI 5 then ADD r1: opcode 1 -> EXEC asserts load_acc, acc_src=1; opcode 2 -> load_acc, alu_op=0; instr_count=2 after 8 cycles.
- LD/ST: opcode 8 -> MEMRD with mem_rd=1, addr_sel=1, then WB with acc_src=2 (5 cycles); opcode 9 -> mem_wr=1, addr_sel=1 in EXEC only.
- Branches: JZ with zero=1 -> load_pc=1; JZ with zero=0 -> load_pc=0; JNZ with zero=0 -> load_pc=1.
- run dropped during DECODE of ADD -> EXEC completes, then IDLE with no further mem_rd; raise run -> FETCH next cycle.
- HLT -> halted=1 and stays high for 10+ cycles with all strobes 0; assert rst_n=0 mid-HALT -> IDLE, halted=0. Run 256 NOPs -> instr_count wraps to 0.
